// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states and the
// address field that selects the memory segment.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    // Segment-select field inside the 32-bit requester address
    localparam int SEG_HI = 31;
    localparam int SEG_LO = 28;
    localparam int SEG_W  = SEG_HI - SEG_LO + 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the two requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the
// port that did not win the last grant; otherwise port 0 always wins ties.
// The last-winner register doubles as the "current winner" seen by the top.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,      // bit n = requester n pending
    input  logic       take,     // grant is being accepted this cycle
    output logic [1:0] grant,    // one-hot winner, valid when req != 0
    output logic       last_win  // index of the most recently granted port
);

    logic last_q, last_d;

    // Combinational arbitration and pointer next-state
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant  = 2'b00;
        last_d = last_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
`else
        if (req[0]) begin
            grant = 2'b01;
        end else begin
            grant = {req[1], 1'b0};
        end
`endif
        if (take) begin
            last_d = grant[1];
        end
    end

    // Last-winner register; reset value makes port 0 win the first tie
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_win = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-write memory with
// combinational read data. Each transaction runs IDLE -> ACCESS -> ACK.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (see mem_arb_pick); default is fixed priority to port 0.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int             ADDR_WIDTH = 10,
    parameter int             DATA_WIDTH = 32,
    parameter logic [SEG_W-1:0] SEG      = 4'ha
) (
    input  logic                  clk,
    input  logic                  reset,
    // requester 0
    input  logic [31:0]           Addr0,
    input  logic                  WE0,
    input  logic                  RD0,
    input  logic [DATA_WIDTH-1:0] DataOut0,
    output logic [DATA_WIDTH-1:0] DataIn0,
    output logic                  WRAck0,
    output logic                  RDAck0,
    // requester 1
    input  logic [31:0]           Addr1,
    input  logic                  WE1,
    input  logic                  RD1,
    input  logic [DATA_WIDTH-1:0] DataOut1,
    output logic [DATA_WIDTH-1:0] DataIn1,
    output logic                  WRAck1,
    output logic                  RDAck1,
    // memory side
    output logic [ADDR_WIDTH-1:0] MemA,
    output logic [DATA_WIDTH-1:0] MemDI,
    output logic                  MemWE,
    output logic                  MemCS,
    input  logic [DATA_WIDTH-1:0] MemDO,
    // sticky protocol error
    output logic                  Err
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [DATA_WIDTH-1:0] mem_di_q, mem_di_d;
    logic                  seg_hit_q, seg_hit_d;
    logic                  is_wr_q, is_wr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic [DATA_WIDTH-1:0] din1_q, din1_d;
    logic [1:0]            wr_ack_q, wr_ack_d;
    logic [1:0]            rd_ack_q, rd_ack_d;

    logic [1:0]            req;
    logic [1:0]            grant;
    logic                  take;
    logic                  win;

    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_we;
    logic                  sel_rd;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_addr_bits;

    assign req  = {WE1 | RD1, WE0 | RD0};
    assign take = (state_q == IDLE) && (req != 2'b00);

    mem_arb_pick u_pick (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .take     (take),
        .grant    (grant),
        .last_win (win)
    );

    // Request fields of the port being granted this cycle
    always_comb begin
        sel_addr = grant[1] ? Addr1    : Addr0;
        sel_data = grant[1] ? DataOut1 : DataOut0;
        sel_we   = grant[1] ? WE1      : WE0;
        sel_rd   = grant[1] ? RD1      : RD0;
    end

    // Address bits between the word address and the segment field are ignored
    assign unused_addr_bits = ^sel_addr;

    assign rd_val = seg_hit_q ? MemDO : '0;

    // FSM next state, request capture, read capture and ack generation
    always_comb begin
        state_d   = state_q;
        mem_a_d   = mem_a_q;
        mem_di_d  = mem_di_q;
        seg_hit_d = seg_hit_q;
        is_wr_d   = is_wr_q;
        err_d     = err_q;
        din0_d    = din0_q;
        din1_d    = din1_q;
        wr_ack_d  = 2'b00;
        rd_ack_d  = 2'b00;
        MemCS     = 1'b0;
        MemWE     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    mem_a_d   = sel_addr[ADDR_WIDTH-1:0];
                    mem_di_d  = sel_data;
                    seg_hit_d = (sel_addr[SEG_HI:SEG_LO] == SEG);
                    // WE+RD together is served as a write and flagged
                    is_wr_d   = sel_we;
                    if (sel_we && sel_rd) begin
                        err_d = 1'b1;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                MemCS = seg_hit_q;
                MemWE = is_wr_q & seg_hit_q;
                if (is_wr_q) begin
                    wr_ack_d[win] = 1'b1;
                end else begin
                    rd_ack_d[win] = 1'b1;
                    if (win) begin
                        din1_d = rd_val;
                    end else begin
                        din0_d = rd_val;
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_a_q   <= '0;
            mem_di_q  <= '0;
            seg_hit_q <= 1'b0;
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            din0_q    <= '0;
            din1_q    <= '0;
            wr_ack_q  <= 2'b00;
            rd_ack_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            mem_a_q   <= mem_a_d;
            mem_di_q  <= mem_di_d;
            seg_hit_q <= seg_hit_d;
            is_wr_q   <= is_wr_d;
            err_q     <= err_d;
            din0_q    <= din0_d;
            din1_q    <= din1_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
        end
    end

    assign MemA    = mem_a_q;
    assign MemDI   = mem_di_q;
    assign Err     = err_q;
    assign DataIn0 = din0_q;
    assign DataIn1 = din1_q;
    assign WRAck0  = wr_ack_q[0];
    assign WRAck1  = wr_ack_q[1];
    assign RDAck0  = rd_ack_q[0];
    assign RDAck1  = rd_ack_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter. Expected tie results depend
// on MEM_ARB_ROUND_ROBIN_EN, which the bench reads to pick its expectations.
module tb_mem_arbiter;

    localparam bit RR = `ifdef MEM_ARB_ROUND_ROBIN_EN 1'b1 `else 1'b0 `endif;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr0, Addr1;
    logic        WE0, RD0, WE1, RD1;
    logic [31:0] DataOut0, DataOut1;
    logic [31:0] DataIn0, DataIn1;
    logic        WRAck0, RDAck0, WRAck1, RDAck1;
    logic [9:0]  MemA;
    logic [31:0] MemDI;
    logic        MemWE, MemCS;
    logic [31:0] MemDO;
    logic        Err;

    int n_cmp = 0;
    int n_err = 0;
    int cur_idx = -1;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .Addr0    (Addr0),
        .WE0      (WE0),
        .RD0      (RD0),
        .DataOut0 (DataOut0),
        .DataIn0  (DataIn0),
        .WRAck0   (WRAck0),
        .RDAck0   (RDAck0),
        .Addr1    (Addr1),
        .WE1      (WE1),
        .RD1      (RD1),
        .DataOut1 (DataOut1),
        .DataIn1  (DataIn1),
        .WRAck1   (WRAck1),
        .RDAck1   (RDAck1),
        .MemA     (MemA),
        .MemDI    (MemDI),
        .MemWE    (MemWE),
        .MemCS    (MemCS),
        .MemDO    (MemDO),
        .Err      (Err)
    );

    // Behavioural memory: combinational read, write on rising edge
    logic [31:0] mem [0:1023];
    bit          clr_mem;
    assign MemDO = mem[MemA];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (MemWE) begin
            mem[MemA] <= MemDI;
        end
    end

    typedef struct {
        logic        we0, rd0;
        logic [31:0] a0, d0;
        logic        we1, rd1;
        logic [31:0] a1, d1;
        logic        cs, we;      // expected MemCS / MemWE during ACCESS
        logic [9:0]  mema;
        logic [31:0] memdi;
        logic [3:0]  acks;        // {WRAck1, WRAck0, RDAck1, RDAck0} during ACK
        logic [31:0] din0, din1;  // expected DataIn0/1 during ACK
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic we0, input logic rd0, input logic [31:0] a0, input logic [31:0] d0,
        input logic we1, input logic rd1, input logic [31:0] a1, input logic [31:0] d1,
        input logic cs, input logic we, input logic [9:0] mema, input logic [31:0] memdi,
        input logic [3:0] acks, input logic [31:0] din0, input logic [31:0] din1);
        vec_t v;
        v.we0 = we0; v.rd0 = rd0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.rd1 = rd1; v.a1 = a1; v.d1 = d1;
        v.cs = cs; v.we = we; v.mema = mema; v.memdi = memdi;
        v.acks = acks; v.din0 = din0; v.din1 = din1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, cur_idx, act, exp);
        end
    endtask

    function automatic logic [3:0] acks_now();
        return {WRAck1, WRAck0, RDAck1, RDAck0};
    endfunction

    task automatic drop_reqs();
        WE0 = 1'b0; RD0 = 1'b0; WE1 = 1'b0; RD1 = 1'b0;
    endtask

    // Called at a negedge with the FSM in IDLE; leaves at a negedge in IDLE
    task automatic apply(input vec_t v);
        Addr0 = v.a0; DataOut0 = v.d0; WE0 = v.we0; RD0 = v.rd0;
        Addr1 = v.a1; DataOut1 = v.d1; WE1 = v.we1; RD1 = v.rd1;
        @(negedge clk);  // ACCESS
        check("access_cs",   {31'b0, MemCS}, {31'b0, v.cs});
        check("access_we",   {31'b0, MemWE}, {31'b0, v.we});
        check("access_mema", {22'b0, MemA},  {22'b0, v.mema});
        check("access_memdi", MemDI, v.memdi);
        check("access_acks", {28'b0, acks_now()}, 32'h0);
        @(negedge clk);  // ACK
        check("ack_acks",  {28'b0, acks_now()}, {28'b0, v.acks});
        check("ack_cs_we", {30'b0, MemCS, MemWE}, 32'h0);
        check("ack_din0",  DataIn0, v.din0);
        check("ack_din1",  DataIn1, v.din1);
        drop_reqs();
        @(negedge clk);  // back in IDLE
        check("idle_acks", {28'b0, acks_now()}, 32'h0);
    endtask

    task automatic check_reset_state();
        check("rst_acks",  {28'b0, acks_now()}, 32'h0);
        check("rst_cs_we", {30'b0, MemCS, MemWE}, 32'h0);
        check("rst_err",   {31'b0, Err}, 32'h0);
        check("rst_din0",  DataIn0, 32'h0);
        check("rst_din1",  DataIn1, 32'h0);
        check("rst_mema",  {22'b0, MemA}, 32'h0);
        check("rst_memdi", MemDI, 32'h0);
    endtask

    initial begin
        // Round-robin alternates tie winners; fixed priority always picks port 0
        vecs.push_back(mk(1,0,32'hA000_0010,32'hDEAD_BEEF, 0,0,0,0,
                          1,1,10'h010,32'hDEAD_BEEF, 4'b0100, 0, 0));
        vecs.push_back(mk(0,0,0,0, 0,1,32'hA000_0010,0,
                          1,0,10'h010,0, 4'b0010, 0, 32'hDEAD_BEEF));
        for (int k = 0; k < 4; k++) begin
            if (RR && (k % 2 == 1))
                vecs.push_back(mk(1,0,32'hA000_0000,1, 1,0,32'hA000_0004,2,
                                  1,1,10'h004,2, 4'b1000, 0, 32'hDEAD_BEEF));
            else
                vecs.push_back(mk(1,0,32'hA000_0000,1, 1,0,32'hA000_0004,2,
                                  1,1,10'h000,1, 4'b0100, 0, 32'hDEAD_BEEF));
        end
        vecs.push_back(mk(0,1,32'hA000_0000,0, 0,0,0,0,
                          1,0,10'h000,0, 4'b0001, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0,0,0,0, 0,1,32'hA000_0004,0,
                          1,0,10'h004,0, 4'b0010, 1, RR ? 32'h2 : 32'h0));
        // Out-of-segment read: no chip select, data forced to zero
        vecs.push_back(mk(0,1,32'hB000_0000,0, 0,0,0,0,
                          0,0,10'h000,0, 4'b0001, 0, RR ? 32'h2 : 32'h0));
        // WE and RD together: served as a write
        vecs.push_back(mk(0,0,0,0, 1,1,32'hA000_0020,32'h55,
                          1,1,10'h020,32'h55, 4'b1000, 0, RR ? 32'h2 : 32'h0));
        vecs.push_back(mk(0,1,32'hA000_0020,0, 0,0,0,0,
                          1,0,10'h020,0, 4'b0001, 32'h55, RR ? 32'h2 : 32'h0));

        reset = 1'b1; clr_mem = 1'b1;
        Addr0 = '0; Addr1 = '0; DataOut0 = '0; DataOut1 = '0;
        drop_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b0; clr_mem = 1'b0;

        foreach (vecs[i]) begin
            cur_idx = i;
            apply(vecs[i]);
        end

        cur_idx = 100;
        check("err_sticky", {31'b0, Err}, 32'h1);

        // Request withdrawn before any edge samples it is ignored
        cur_idx = 101;
        Addr0 = 32'hA000_0040; WE0 = 1'b1;
        #2 WE0 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("withdraw_cs",   {31'b0, MemCS}, 32'h0);
            check("withdraw_acks", {28'b0, acks_now()}, 32'h0);
        end
        check("withdraw_err", {31'b0, Err}, 32'h1);

        // Reset during ACCESS aborts the access without an ack
        cur_idx = 102;
        Addr0 = 32'hA000_0030; DataOut0 = 32'h77; WE0 = 1'b1;
        @(negedge clk);
        check("abort_in_access", {31'b0, MemCS}, 32'h1);
        reset = 1'b1;
        drop_reqs();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ack", {28'b0, acks_now()}, 32'h0);
        end

        // After reset, the first tie goes to port 0 in both builds
        cur_idx = 103;
        apply(mk(1,0,32'hA000_0008,3, 1,0,32'hA000_000C,4,
                 1,1,10'h008,3, 4'b0100, 0, 0));
        cur_idx = 104;
        apply(mk(0,0,0,0, 0,1,32'hA000_0010,0,
                 1,0,10'h010,0, 4'b0010, 0, 32'hDEAD_BEEF));
        check("err_after_reset", {31'b0, Err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter SEG, default 4'ha, the Addr[31:28] value that selects the memory.
REQ-004 SHALL have port clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have, for each requester n in {0,1}, ports Addr<n> input 32, WE<n> input 1, RD<n> input 1, DataOut<n> input DATA_WIDTH (write data), DataIn<n> output DATA_WIDTH (read data), WRAck<n> output 1, RDAck<n> output 1.
REQ-007 SHALL have memory-side ports MemA output ADDR_WIDTH, MemDI output DATA_WIDTH, MemWE output 1, MemCS output 1, MemDO input DATA_WIDTH (combinational read data).
REQ-008 SHALL have port Err output 1, a sticky flag for a requester asserting WE and RD together.

Function
REQ-009 A requester SHALL be pending while its WE or RD is high, and SHALL hold Addr, DataOut, WE and RD stable until it receives its ack.
REQ-010 The FSM SHALL have states IDLE, ACCESS and ACK.
REQ-011 IDLE: with no request pending, stay in IDLE; otherwise register the winner and its Addr, DataOut and operation, then go to ACCESS.
REQ-012 ACCESS: drive MemA=Addr[ADDR_WIDTH-1:0], MemDI=DataOut, MemCS=(Addr[31:28]==SEG), MemWE=write&MemCS; capture MemDO into the winner's read register if the operation is a read and MemCS=1, else 0; go to ACK.
REQ-013 ACK: pulse WRAck<n> (write) or RDAck<n> (read) high for exactly one cycle to the winner only, with DataIn<n> valid; return to IDLE.
REQ-014 Latency SHALL be 3 cycles from the request being sampled to the ack edge; a new grant SHALL be no earlier than the cycle after ACK.
REQ-015 Outside ACCESS, MemWE and MemCS SHALL be 0 and MemA/MemDI SHALL hold their last values.
REQ-016 If WE and RD are both high on the winner, the access SHALL be a write, the ack SHALL be WRAck, and Err SHALL be set until reset.
REQ-017 An out-of-segment access SHALL complete the full IDLE-ACCESS-ACK sequence with no memory write, and its read data SHALL be 0.
REQ-018 DataIn<n> SHALL hold the last read value for port n until port n's next read completes.
REQ-019 A request withdrawn in IDLE before it is sampled SHALL be ignored; withdrawal after grant SHALL NOT abort the access.

Reset
REQ-020 With reset high at a clock edge, the FSM SHALL go to IDLE and all acks, MemWE, MemCS and Err SHALL be 0.
REQ-021 On the same reset edge, DataIn0/1, MemA and MemDI SHALL be 0 and the round-robin pointer SHALL favour port 0.
REQ-022 Reset asserted in ACCESS or ACK SHALL abort the access with no ack issued.

Configuration
REQ-023 With macro MEM_ARB_ROUND_ROBIN_EN defined, a tie in IDLE SHALL be granted to the port that did not win the last grant; the pointer SHALL update only on grant.
REQ-024 With MEM_ARB_ROUND_ROBIN_EN undefined, port 0 SHALL always win ties (fixed priority).

Structure
REQ-025 Package mem_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, ACK) and the segment-field constants (bits 31:28).
REQ-026 Winner selection SHALL be the sub-module mem_arb_pick, containing the request vector, last-winner pointer and grant one-hot, including the macro-dependent logic.

Verification
REQ-027 Port 0 writes 0xDEADBEEF to 0xA0000010 -> MemWE high for one cycle at MemA=0x010; WRAck0 pulses 3 cycles after the request is sampled.
REQ-028 Port 1 then reads 0xA0000010 -> RDAck1 pulses once with DataIn1=0xDEADBEEF; port 0's acks stay low.
REQ-029 Both ports request at once, with writes to 0xA0000000 (0x1) and 0xA0000004 (0x2) repeated 4 times -> with the macro, grants alternate 0,1,0,1...; without it, port 0 wins every tie.
REQ-030 Port 0 reads 0xB0000000 -> MemCS and MemWE stay 0; RDAck0 pulses with DataIn0=0.
REQ-031 Port 1 asserts WE=RD=1 at 0xA0000020 with data 0x55 -> write occurs, WRAck1 pulses, and Err=1 until reset.
REQ-032 Reset asserted during ACCESS -> no ack, FSM returns to IDLE, all outputs reset, and a following request is served normally.
